// File: rtl/vga_controller.sv
// vga_controller: 640x480@60 pixel-timing generator and VGA output stage.
// Derives a 25 MHz pixel tick from the 50 MHz clock, scans h/v counters,
// exposes (x, y, pause) to the application mux, and registers its RGB
// result together with active-low syncs onto the VGA pins.
// Ports:
//   clk        system clock (50 MHz)
//   reset      asynchronous active-low reset
//   rgb_in     12-bit {R,G,B} from the application mux
//   x, y       current horizontal / vertical counters
//   pause      high while (x, y) is outside the visible area
//   frame_tick one-clk pulse on the last pixel tick of a frame
//   VGA_HS/VS  active-low syncs, aligned with VGA_R/G/B
module vga_controller #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pause,
  output logic        frame_tick,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
  localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic          phase_q;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;

  logic          tick;
  logic          h_last, v_last;
  logic          video_on;
  logic          hsync_n, vsync_n;

  // Pixel-rate decode of the current counter state
  always_comb begin
    tick     = phase_q;
    h_last   = (h_q == H_LAST);
    v_last   = (v_q == V_LAST);
    video_on = (h_q < H_VIS) && (v_q < V_VIS);
    hsync_n  = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vsync_n  = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  end

  // Counter next state: h wraps at end of line, v advances on that same tick
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + CW'(1);
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Phase, counters and output stage; pins lag the counters by one pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      rgb_q   <= '0;
    end else begin
      phase_q <= ~phase_q;
      h_q     <= h_d;
      v_q     <= v_d;
      if (tick) begin
        hs_q  <= hsync_n;
        vs_q  <= vsync_n;
        rgb_q <= video_on ? rgb_in : 12'h000;
      end
    end
  end

  assign x          = h_q;
  assign y          = v_q;
  assign pause      = !video_on;
  assign frame_tick = tick && h_last && v_last;
  assign VGA_HS     = hs_q;
  assign VGA_VS     = vs_q;
  assign VGA_R      = rgb_q[11:8];
  assign VGA_G      = rgb_q[7:4];
  assign VGA_B      = rgb_q[3:0];

endmodule

// File: tb/tb_vga_controller.sv
// Testbench for vga_controller. A reduced-geometry instance (16x10 total,
// 8x6 visible) carries the frame-level checks; a default-geometry instance
// checks the real horizontal timing and blanking edge.
module tb_vga_controller;

  logic clk;
  logic rst_n;
  int   cyc;     // posedges since the last reset release
  int   n_cmp;
  int   n_bad;

  // Reduced-geometry DUT
  logic [11:0] rgb_s;
  logic [9:0]  x_s, y_s;
  logic        pause_s, ft_s, hs_s, vs_s;
  logic [3:0]  r_s, g_s, b_s;
  logic        man_mode;
  logic [11:0] man_rgb;

  // Default-geometry DUT
  logic [11:0] rgb_f;
  logic [9:0]  x_f, y_f;
  logic        pause_f, ft_f, hs_f, vs_f;
  logic [3:0]  r_f, g_f, b_f;

  vga_controller #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut_s (
    .clk(clk), .reset(rst_n), .rgb_in(rgb_s),
    .x(x_s), .y(y_s), .pause(pause_s), .frame_tick(ft_s),
    .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s)
  );

  vga_controller dut_f (
    .clk(clk), .reset(rst_n), .rgb_in(rgb_f),
    .x(x_f), .y(y_f), .pause(pause_f), .frame_tick(ft_f),
    .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Application mux stand-in: echo x, or a bench-forced value
  always_comb rgb_s = man_mode ? man_rgb : {2'b00, x_s};
  assign rgb_f = 12'hFFF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Edge logs, sampled on the falling clock edge
  int   hs_falls_f[$], hs_rises_f[$], vs_falls_s[$], vs_rises_s[$], ft_log_s[$];
  logic hs_prev_f, vs_prev_s;
  always @(negedge clk) begin
    if (!rst_n) begin
      hs_prev_f = 1'b1;
      vs_prev_s = 1'b1;
    end else begin
      if (hs_prev_f && !hs_f) hs_falls_f.push_back(cyc);
      if (!hs_prev_f && hs_f) hs_rises_f.push_back(cyc);
      if (vs_prev_s && !vs_s) vs_falls_s.push_back(cyc);
      if (!vs_prev_s && vs_s) vs_rises_s.push_back(cyc);
      if (ft_s) ft_log_s.push_back(cyc);
      hs_prev_f = hs_f;
      vs_prev_s = vs_s;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  function automatic int q_at(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1;
  endfunction

  typedef struct {
    int          e;
    logic [9:0]  x, y;
    logic        pause, ft, hs, vs;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[$];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    man_mode = 1'b0;
    man_rgb  = 12'h000;
    rst_n    = 1'b0;

    // Expected small-DUT state after e posedges since release, rgb_in = x
    //             e    x   y  pause ft hs vs rgb
    tbl.push_back('{  0,  0, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{  1,  0, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{  2,  1, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{  3,  1, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{  4,  2, 0, 0, 0, 1, 1, 12'd1});
    tbl.push_back('{ 16,  8, 0, 1, 0, 1, 1, 12'd7});
    tbl.push_back('{ 18,  9, 0, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{ 20, 10, 0, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{ 22, 11, 0, 1, 0, 0, 1, 12'd0});
    tbl.push_back('{ 26, 13, 0, 1, 0, 0, 1, 12'd0});
    tbl.push_back('{ 28, 14, 0, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{ 32,  0, 1, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{ 36,  2, 1, 0, 0, 1, 1, 12'd1});
    tbl.push_back('{174,  7, 5, 0, 0, 1, 1, 12'd6});
    tbl.push_back('{180, 10, 5, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{192,  0, 6, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{196,  2, 6, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{224,  0, 7, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{226,  1, 7, 1, 0, 1, 0, 12'd0});
    tbl.push_back('{288,  0, 9, 1, 0, 1, 0, 12'd0});
    tbl.push_back('{290,  1, 9, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{317, 14, 9, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{318, 15, 9, 1, 0, 1, 1, 12'd0});
    tbl.push_back('{319, 15, 9, 1, 1, 1, 1, 12'd0});
    tbl.push_back('{320,  0, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{322,  1, 0, 0, 0, 1, 1, 12'd0});
    tbl.push_back('{324,  2, 0, 0, 0, 1, 1, 12'd1});

    // Values held during reset
    repeat (5) @(negedge clk);
    chk("rst_x",     32'(x_s), 32'd0);
    chk("rst_y",     32'(y_s), 32'd0);
    chk("rst_pause", 32'(pause_s), 32'd0);
    chk("rst_ft",    32'(ft_s), 32'd0);
    chk("rst_hs",    32'(hs_s), 32'd1);
    chk("rst_vs",    32'(vs_s), 32'd1);
    chk("rst_rgb",   32'({r_s, g_s, b_s}), 32'd0);
    chk("rst_x_f",   32'(x_f), 32'd0);
    rst_n = 1'b1;

    // First frame and wrap of the reduced DUT
    for (int i = 0; i < tbl.size(); i++) begin
      wait_cyc(tbl[i].e);
      chk($sformatf("x@%0d", tbl[i].e),     32'(x_s), 32'(tbl[i].x));
      chk($sformatf("y@%0d", tbl[i].e),     32'(y_s), 32'(tbl[i].y));
      chk($sformatf("pause@%0d", tbl[i].e), 32'(pause_s), 32'(tbl[i].pause));
      chk($sformatf("ft@%0d", tbl[i].e),    32'(ft_s), 32'(tbl[i].ft));
      chk($sformatf("hs@%0d", tbl[i].e),    32'(hs_s), 32'(tbl[i].hs));
      chk($sformatf("vs@%0d", tbl[i].e),    32'(vs_s), 32'(tbl[i].vs));
      chk($sformatf("rgb@%0d", tbl[i].e),   32'({r_s, g_s, b_s}), 32'(tbl[i].rgb));
    end

    // rgb_in changes on the non-tick cycle must not reach the pins
    man_mode = 1'b1;
    man_rgb  = 12'h5A5;
    wait_cyc(325);
    chk("offphase_hold", 32'({r_s, g_s, b_s}), 32'd1);
    man_rgb  = 12'h0F0;
    wait_cyc(326);
    chk("tick_sample", 32'({r_s, g_s, b_s}), 32'h0F0);
    man_mode = 1'b0;

    // Default geometry: blanking edge at x=640 and hsync start
    wait_cyc(1280);
    chk("f_x640",      32'(x_f), 32'd640);
    chk("f_pause640",  32'(pause_f), 32'd1);
    chk("f_rgb639",    32'({r_f, g_f, b_f}), 32'hFFF);
    wait_cyc(1282);
    chk("f_rgb640",    32'({r_f, g_f, b_f}), 32'h000);
    wait_cyc(1312);
    chk("f_x656",      32'(x_f), 32'd656);
    chk("f_hs_pre",    32'(hs_f), 32'd1);

    wait_cyc(3000);
    chk("f_hs_fall0",  32'(q_at(hs_falls_f, 0)), 32'd1314);
    chk("f_hs_rise0",  32'(q_at(hs_rises_f, 0)), 32'd1506);
    chk("f_hs_fall1",  32'(q_at(hs_falls_f, 1)), 32'd2914);
    chk("s_vs_fall0",  32'(q_at(vs_falls_s, 0)), 32'd226);
    chk("s_vs_rise0",  32'(q_at(vs_rises_s, 0)), 32'd290);
    chk("s_ft0",       32'(q_at(ft_log_s, 0)), 32'd319);
    chk("s_ft1",       32'(q_at(ft_log_s, 1)), 32'd639);
    chk("s_ft2",       32'(q_at(ft_log_s, 2)), 32'd959);

    // Mid-frame reset at x=5, y=3 of the reduced DUT
    begin
      int budget = 500;
      while (!(x_s == 10'd5 && y_s == 10'd3) && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      chk("find_x5y3", 32'(budget > 0), 32'd1);
    end
    chk("pre_rst_rgb", 32'({r_s, g_s, b_s}), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_x",   32'(x_s), 32'd0);
    chk("mid_rst_y",   32'(y_s), 32'd0);
    chk("mid_rst_rgb", 32'({r_s, g_s, b_s}), 32'd0);
    chk("mid_rst_hs",  32'(hs_s), 32'd1);
    chk("mid_rst_vs",  32'(vs_s), 32'd1);
    chk("mid_rst_ft",  32'(ft_s), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_x", 32'(x_s), 32'd0);
    ft_log_s.delete();
    rst_n = 1'b1;
    wait_cyc(2);
    chk("resume_x", 32'(x_s), 32'd1);
    chk("resume_y", 32'(y_s), 32'd0);
    wait_cyc(330);
    chk("resume_ft_cnt", 32'(ft_log_s.size()), 32'd1);
    chk("resume_ft0",    32'(q_at(ft_log_s, 0)), 32'd319);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
